// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants and types for the hazard/stall unit.
package hazard_stall_unit_pkg;

  localparam int         MDU_CNT_W = 6;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // True when a live (non-zero) destination feeds either ID source operand.
  function automatic logic reg_match(input logic [4:0] dst,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (dst != REG_ZERO) && ((dst == rs) || (dst == rt));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_stall_counter.sv
// Saturating 32-bit count of stalled cycles.
module stall_counter
  import hazard_stall_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 32'd0;
    end else if (i_inc && !(&r_count)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use, branch-compare and MDU-busy hazard detection with stall/flush generation.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        branch_D,
  input  logic        branch_taken_D,
  input  logic        hilo_use_D,
  input  logic [4:0]  write_reg_E,
  input  logic        reg_write_E,
  input  logic        mem_to_reg_E,
  input  logic [4:0]  write_reg_M,
  input  logic        mem_to_reg_M,
  input  logic        mdu_start_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_E,
  output logic        flush_D,
  output logic        mdu_busy,
  output logic [31:0] stall_count
);

  localparam logic [MDU_CNT_W-1:0] LAT_M1 = MDU_CNT_W'(MDU_LAT - 1);

  mdu_state_e           r_state;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic                 r_busy;

  logic w_lu_hz;
  logic w_br_hz;
  logic w_mdu_hz;
  logic w_stall;

  assign w_lu_hz  = mem_to_reg_E && reg_match(write_reg_E, rs_D, rt_D);
  assign w_br_hz  = branch_D &&
                    ((reg_write_E  && reg_match(write_reg_E, rs_D, rt_D)) ||
                     (mem_to_reg_M && reg_match(write_reg_M, rs_D, rt_D)));
  assign w_mdu_hz = hilo_use_D && r_busy;

  // Gated by rst_n so every output is low while reset is held, clock or not.
  assign w_stall  = rst_n && (w_lu_hz || w_br_hz || w_mdu_hz);

  assign stall_F  = w_stall;
  assign stall_D  = w_stall;
  assign flush_E  = w_stall;
  assign flush_D  = rst_n && branch_taken_D && !w_stall;
  assign mdu_busy = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mdu_start_E) begin
            r_state <= ST_BUSY;
            r_cnt   <= LAT_M1;
            r_busy  <= 1'b1;
          end
        end
        ST_BUSY: begin
          // A new start while busy is dropped; the op in flight runs to completion.
          if (r_cnt == '0) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  stall_counter u_stall_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_stall),
    .o_count (stall_count)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed checks of hazard detection, MDU busy window, reset abort and counter saturation.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_D, rt_D, write_reg_E, write_reg_M;
  logic        branch_D, branch_taken_D, hilo_use_D;
  logic        reg_write_E, mem_to_reg_E, mem_to_reg_M, mdu_start_E;
  logic        stall_F, stall_D, flush_E, flush_D, mdu_busy;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MDU_LAT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_D           (rs_D),
    .rt_D           (rt_D),
    .branch_D       (branch_D),
    .branch_taken_D (branch_taken_D),
    .hilo_use_D     (hilo_use_D),
    .write_reg_E    (write_reg_E),
    .reg_write_E    (reg_write_E),
    .mem_to_reg_E   (mem_to_reg_E),
    .write_reg_M    (write_reg_M),
    .mem_to_reg_M   (mem_to_reg_M),
    .mdu_start_E    (mdu_start_E),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .flush_E        (flush_E),
    .flush_D        (flush_D),
    .mdu_busy       (mdu_busy),
    .stall_count    (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, ".stall_F"}, {31'd0, stall_F}, {31'd0, exp});
    check({tag, ".stall_D"}, {31'd0, stall_D}, {31'd0, exp});
    check({tag, ".flush_E"}, {31'd0, flush_E}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; write_reg_E = 0; write_reg_M = 0;
    branch_D = 0; branch_taken_D = 0; hilo_use_D = 0;
    reg_write_E = 0; mem_to_reg_E = 0; mem_to_reg_M = 0; mdu_start_E = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Hazard present during reset must still leave outputs low.
    mem_to_reg_E = 1; write_reg_E = 5'd8; rs_D = 5'd8; branch_taken_D = 1;
    #2;
    check_stall("reset", 1'b0);
    check("reset.flush_D", {31'd0, flush_D}, 32'd0);
    check("reset.mdu_busy", {31'd0, mdu_busy}, 32'd0);
    check("reset.stall_count", stall_count, 32'd0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();

    // Load-use
    mem_to_reg_E = 1; write_reg_E = 5'd8; rs_D = 5'd8; #1;
    check_stall("loaduse", 1'b1);
    tick();
    clear_inputs(); #1;
    check_stall("loaduse.after", 1'b0);
    check("loaduse.count", stall_count, 32'd1);

    // Load to r0 never hazards
    mem_to_reg_E = 1; write_reg_E = 5'd0; rs_D = 5'd0; rt_D = 5'd0; #1;
    check_stall("loaduse.r0", 1'b0);
    clear_inputs();

    // Branch vs EX ALU write
    branch_D = 1; reg_write_E = 1; write_reg_E = 5'd5; rt_D = 5'd5; #1;
    check_stall("branch.ex", 1'b1);
    tick();
    check("branch.ex.count", stall_count, 32'd2);
    write_reg_E = 5'd0; #1;
    check_stall("branch.ex.r0", 1'b0);
    branch_D = 0; write_reg_E = 5'd5; #1;
    check_stall("nobranch.alu", 1'b0);
    clear_inputs();

    // Branch vs MEM load
    branch_D = 1; mem_to_reg_M = 1; write_reg_M = 5'd7; rs_D = 5'd7; #1;
    check_stall("branch.mem", 1'b1);
    tick();
    check("branch.mem.count", stall_count, 32'd3);
    clear_inputs();

    // Taken branch flush
    branch_taken_D = 1; #1;
    check("flushD.nohz", {31'd0, flush_D}, 32'd1);
    check_stall("flushD.nohz", 1'b0);
    mem_to_reg_E = 1; write_reg_E = 5'd9; rt_D = 5'd9; #1;
    check("flushD.lu", {31'd0, flush_D}, 32'd0);
    check_stall("flushD.lu", 1'b1);
    tick();
    check("flushD.count", stall_count, 32'd4);
    clear_inputs();

    // MDU busy window of 4 cycles with HI/LO consumer waiting
    hilo_use_D = 1; mdu_start_E = 1; #1;
    check("mdu.start.busy", {31'd0, mdu_busy}, 32'd0);
    check_stall("mdu.start", 1'b0);
    tick();
    mdu_start_E = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check($sformatf("mdu.busy%0d", i), {31'd0, mdu_busy}, 32'd1);
      check_stall($sformatf("mdu.busy%0d", i), 1'b1);
      tick();
    end
    check("mdu.done.busy", {31'd0, mdu_busy}, 32'd0);
    check_stall("mdu.done", 1'b0);
    check("mdu.count", stall_count, 32'd8);
    clear_inputs();

    // Reset in the 2nd busy cycle aborts the op
    mdu_start_E = 1; tick();
    mdu_start_E = 0; tick();
    check("abort.busy2", {31'd0, mdu_busy}, 32'd1);
    hilo_use_D = 1; rst_n = 1'b0; #1;
    check("abort.busy", {31'd0, mdu_busy}, 32'd0);
    check_stall("abort", 1'b0);
    check("abort.count", stall_count, 32'd0);
    tick();
    rst_n = 1'b1; hilo_use_D = 0; #1;
    check("abort.release", {31'd0, mdu_busy}, 32'd0);
    tick();
    check("abort.run", {31'd0, mdu_busy}, 32'd0);

    // Second start mid-busy must not extend the window
    mdu_start_E = 1; tick();
    check("restart.c1", {31'd0, mdu_busy}, 32'd1);
    tick();
    mdu_start_E = 0;
    check("restart.c2", {31'd0, mdu_busy}, 32'd1);
    tick();
    check("restart.c3", {31'd0, mdu_busy}, 32'd1);
    tick();
    check("restart.c4", {31'd0, mdu_busy}, 32'd1);
    tick();
    check("restart.end", {31'd0, mdu_busy}, 32'd0);
    clear_inputs();

    // Saturation from a forced near-full value
    mem_to_reg_E = 1; write_reg_E = 5'd3; rs_D = 5'd3; #1;
    force dut.u_stall_counter.r_count = 32'hFFFF_FFFD;
    #1;
    release dut.u_stall_counter.r_count;
    #1;
    check("sat.preload", stall_count, 32'hFFFF_FFFD);
    tick();
    check("sat.fe", stall_count, 32'hFFFF_FFFE);
    tick();
    check("sat.ff", stall_count, 32'hFFFF_FFFF);
    tick();
    tick();
    check("sat.hold", stall_count, 32'hFFFF_FFFF);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
